// File: rtl/ca2_pkg.sv
// Shared types and constants for the two-neighbour cellular-automaton
// predecessor finder. The optional CA2_COUNT_ALL_EN build is handled in the
// top module; nothing in this package depends on it.
package ca2_pkg;

  localparam int RULE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ca2_step_eval.sv
// One forward step of a ring of N cells. Cell i takes the rule bit selected by
// the pair {A[i+1], A[i]}, where cell N-1 wraps around to pair with cell 0.
module ca2_step_eval
  import ca2_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [RULE_W-1:0] rule,
  input  logic [N-1:0]      cand,
  output logic [N-1:0]      next
);

  // Each output cell is a pure lookup of its neighbourhood in the rule table
  for (genvar i = 0; i < N; i++) begin : g_cell
    assign next[i] = rule[{cand[(i+1)%N], cand[i]}];
  end

endmodule

// File: rtl/ca2_predecessor_finder.sv
// Brute-force search for a predecessor of a target ring state under a
// two-neighbour CA rule: one candidate is stepped forward and compared per
// cycle. Define CA2_COUNT_ALL_EN to scan every candidate and report the
// number of predecessors on the count port instead of stopping at the first.
module ca2_predecessor_finder
  import ca2_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RULE_W-1:0] rule,
  input  logic [N-1:0]      target,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [N-1:0]      pred
`ifdef CA2_COUNT_ALL_EN
  ,
  output logic [N:0]        count
`endif
);

  state_t            state;
  logic [RULE_W-1:0] rule_q;
  logic [N-1:0]      target_q;
  logic [N-1:0]      cand;
  logic [N-1:0]      stepped;
  logic              match;
  logic              last;

  ca2_step_eval #(.N(N)) u_step (
    .rule (rule_q),
    .cand (cand),
    .next (stepped)
  );

  assign match = (stepped == target_q);
  assign last  = &cand;

  // Search controller: latches the problem on start, walks cand upward and
  // holds the results after the one-cycle done state until the next start
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      pred     <= '0;
      cand     <= '0;
      rule_q   <= '0;
      target_q <= '0;
`ifdef CA2_COUNT_ALL_EN
      count    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rule_q   <= rule;
            target_q <= target;
            cand     <= '0;
            found    <= 1'b0;
            pred     <= '0;
`ifdef CA2_COUNT_ALL_EN
            count    <= '0;
`endif
            busy     <= 1'b1;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
`ifdef CA2_COUNT_ALL_EN
          if (match) begin
            count <= count + (N+1)'(1);
            if (!found) begin
              found <= 1'b1;
              pred  <= cand;
            end
          end
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cand <= cand + N'(1);
          end
`else
          if (match) begin
            found <= 1'b1;
            pred  <= cand;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cand <= cand + N'(1);
          end
`endif
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ca2_predecessor_finder.sv
// Scoreboard bench for ca2_predecessor_finder (N=8). Directed vectors push
// their hand-computed results; a negedge monitor pops one entry per done
// pulse. Expected values follow the CA2_COUNT_ALL_EN setting of the build.
module tb_ca2_predecessor_finder;

  localparam int N = 8;
  localparam int FULL_LAT = (1 << N) + 1;

  typedef struct {
    logic       found;
    logic [7:0] pred;
    logic [8:0] cnt;
    int         lat;
    int         startEdge;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] rule;
  logic [7:0] target;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] pred;
`ifdef CA2_COUNT_ALL_EN
  logic [8:0] count;
`endif

  exp_t sb[$];
  int   edgeCount = 0;
  int   nChecks = 0;
  int   nFails = 0;

  ca2_predecessor_finder #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .rule   (rule),
    .target (target),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .pred   (pred)
`ifdef CA2_COUNT_ALL_EN
    ,
    .count  (count)
`endif
  );

  // Free-running clock and an edge counter used to measure done latency
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Caller must be at a negedge; start is sampled at the following posedge
  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] t,
                               input logic ef, input logic [7:0] ep,
                               input logic [8:0] ec, input int elat);
    exp_t e;
    start  = 1'b1;
    rule   = r;
    target = t;
    e.found = ef;
    e.pred  = ep;
    e.cnt   = ec;
`ifdef CA2_COUNT_ALL_EN
    e.lat   = FULL_LAT;
`else
    e.lat   = elat;
`endif
    e.startEdge = edgeCount + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int budget = 0;
    while (sb.size() != 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL done_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_found"}, {31'd0, found}, 32'd0);
    checkOutput({tag, "_pred"}, {24'd0, pred}, 32'd0);
`ifdef CA2_COUNT_ALL_EN
    checkOutput({tag, "_count"}, {23'd0, count}, 32'd0);
`endif
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_done: done=1, expected no pulse");
      end else begin
        e = sb.pop_front();
        checkOutput("found", {31'd0, found}, {31'd0, e.found});
        checkOutput("pred", {24'd0, pred}, {24'd0, e.pred});
        checkOutput("latency", edgeCount - e.startEdge + 1, e.lat);
        checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
`ifdef CA2_COUNT_ALL_EN
        checkOutput("count", {23'd0, count}, {23'd0, e.cnt});
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s;
    reset  = 1'b1;
    start  = 1'b0;
    rule   = 4'b0000;
    target = 8'h00;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Identity rule: the only predecessor is the target itself
    applyStimulus(4'b1010, 8'h5A, 1'b1, 8'h5A, 9'd1, 32'h5C);
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("hold_found", {31'd0, found}, 32'd1);
    checkOutput("hold_pred", {24'd0, pred}, 32'h5A);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);

    // Left rotation: unique predecessor is target rotated the other way
    applyStimulus(4'b1100, 8'h01, 1'b1, 8'h02, 9'd1, 4);
    waitIdle();
    applyStimulus(4'b1100, 8'h80, 1'b1, 8'h01, 9'd1, 3);
    waitIdle();

    // XOR: all-equal states map to zero; odd-weight targets are unreachable
    applyStimulus(4'b0110, 8'h00, 1'b1, 8'h00, 9'd2, 2);
    waitIdle();
    applyStimulus(4'b0110, 8'h01, 1'b0, 8'h00, 9'd0, FULL_LAT);
    waitIdle();

    // Constant rules: every candidate, or none, matches
    applyStimulus(4'b0000, 8'h00, 1'b1, 8'h00, 9'h100, 2);
    waitIdle();
    applyStimulus(4'b1111, 8'h00, 1'b0, 8'h00, 9'd0, FULL_LAT);
    waitIdle();

    // Reset in cycle 50 aborts a long search; start held into cycle 51
    @(negedge clk);
    applyStimulus(4'b0110, 8'h01, 1'b0, 8'h00, 9'd0, FULL_LAT);
    s = edgeCount;
    void'(sb.pop_back());
    checkOutput("search_busy", {31'd0, busy}, 32'd1);
    while (edgeCount < s + 49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("abort");
    reset = 1'b0;
    applyStimulus(4'b0110, 8'h01, 1'b0, 8'h00, 9'd0, FULL_LAT);
    waitIdle();

    // Second start in cycle 10 plus port changes mid-search are ignored
    @(negedge clk);
    applyStimulus(4'b1010, 8'h5A, 1'b1, 8'h5A, 9'd1, 32'h5C);
    s = edgeCount;
    rule   = 4'b0000;
    target = 8'hFF;
    while (edgeCount < s + 9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    repeat (4) @(negedge clk);
    checkOutput("no_requeue_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
